// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: field widths, opcode encoding
// and the packed instruction word layout.
package cpu_pkg;

    localparam int ADDR_W = 5;
    localparam int OP_W   = 3;
    localparam int DATA_W = OP_W + ADDR_W;

    // Encoding 1 is reserved.
    typedef enum logic [OP_W-1:0] {
        HLT = 3'd0,
        SKZ = 3'd2,
        ADD = 3'd3,
        AND = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_e;

    typedef struct packed {
        logic [OP_W-1:0]   opcode;
        logic [ADDR_W-1:0] operand;
    } instr_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter: hold / jump / skip / increment priority mux.
// Arithmetic wraps silently at 2^ADDR_W.
import cpu_pkg::*;

module pc_reg (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              load,
    input  logic              jmp,
    input  logic              inc,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc
);

    // NOTE: sequential state is written with <= only, so every register in
    // this block samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc <= '0;
        end else if (hold) begin
            pc <= pc;
        end else if (load && jmp) begin
            pc <= target;
        end else if (load || inc) begin
            // A skip advances once here; the later writeback increment adds the second step.
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: drives the instruction-memory address from the PC, captures
// the returned word into the IR, and tracks halt status and retired count.
import cpu_pkg::*;

module fetch_unit #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_load,
    input  logic              jmp,
    input  logic              pc_en,
    input  logic              halt,
    input  logic              memIns_en,
    output logic [ADDR_W-1:0] ins_addr,
    output logic              ins_re,
    input  logic [DATA_W-1:0] ins_rdata,
    output logic [OP_W-1:0]   opcode,
    output logic [ADDR_W-1:0] operand,
    output logic              ir_valid,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    logic [ADDR_W-1:0] pc;
    instr_t            ir;
    logic              rd_pending;

    pc_reg u_pc_reg (
        .clk    (clk),
        .rst    (rst),
        .hold   (halted),
        .load   (pc_load),
        .jmp    (jmp),
        .inc    (pc_en),
        .target (ir.operand),
        .pc     (pc)
    );

    assign ins_addr = pc;
    // No read is issued while reset is asserted, so nothing is left pending across it.
    assign ins_re   = memIns_en & ~halted & rst;
    assign opcode   = ir.opcode;
    assign operand  = ir.operand;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ir         <= '0;
            ir_valid   <= 1'b0;
            rd_pending <= 1'b0;
            halted     <= 1'b0;
            retired    <= '0;
        end else begin
            // A read accepted before halting still lands; no new read can start once halted.
            rd_pending <= ins_re;
            if (rd_pending) begin
                ir       <= ins_rdata;
                ir_valid <= 1'b1;
            end
            if (halt) begin
                halted <= 1'b1;
            end
            if (pc_en && !halted) begin
                retired <= retired + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-cycle-latency instruction memory model.
import cpu_pkg::*;

module tb_fetch_unit;

    logic              clk = 1'b0;
    logic              rst;
    logic              pc_load;
    logic              jmp;
    logic              pc_en;
    logic              halt;
    logic              memIns_en;
    logic [ADDR_W-1:0] ins_addr;
    logic              ins_re;
    logic [DATA_W-1:0] ins_rdata = '0;
    logic [OP_W-1:0]   opcode;
    logic [ADDR_W-1:0] operand;
    logic              ir_valid;
    logic              halted;
    logic [15:0]       retired;

    logic [DATA_W-1:0] mem [32];

    int checks   = 0;
    int failures = 0;

    fetch_unit #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .pc_load   (pc_load),
        .jmp       (jmp),
        .pc_en     (pc_en),
        .halt      (halt),
        .memIns_en (memIns_en),
        .ins_addr  (ins_addr),
        .ins_re    (ins_re),
        .ins_rdata (ins_rdata),
        .opcode    (opcode),
        .operand   (operand),
        .ir_valid  (ir_valid),
        .halted    (halted),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ins_re) ins_rdata <= mem[ins_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pc_load = 0; jmp = 0; pc_en = 0; halt = 0; memIns_en = 0;
    endtask

    // Fetch the word at the current PC: request cycle, then capture cycle.
    task automatic fetch();
        memIns_en = 1;
        step();
        memIns_en = 0;
        step();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        mem[0]  = 8'hA3;
        mem[1]  = 8'hF4;
        mem[20] = 8'hE6;
        mem[8]  = 8'hE8;

        // Reset with random strobes
        rst = 0;
        for (int i = 0; i < 2; i++) begin
            pc_load   = 1'($urandom);
            jmp       = 1'($urandom);
            pc_en     = 1'($urandom);
            halt      = 1'($urandom);
            memIns_en = 1'($urandom);
            step();
        end
        idle();
        #1;
        check("rst_pc", 32'(ins_addr), 0);
        check("rst_ir", {24'b0, opcode, operand}, 0);
        check("rst_ir_valid", 32'(ir_valid), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_retired", 32'(retired), 0);
        check("rst_ins_re", 32'(ins_re), 0);
        rst = 1;
        step();

        // Sequential fetch of 0xA3 (LDA 3)
        memIns_en = 1;
        #1;
        check("fetch_ins_re", 32'(ins_re), 1);
        check("fetch_ins_addr", 32'(ins_addr), 0);
        step();
        memIns_en = 0;
        check("fetch_pre_ir_valid", 32'(ir_valid), 0);
        step();
        check("fetch_opcode", 32'(opcode), 5);
        check("fetch_operand", 32'(operand), 3);
        check("fetch_ir_valid", 32'(ir_valid), 1);
        step();
        step();
        pc_en = 1;
        step();
        pc_en = 0;
        check("fetch_pc", 32'(ins_addr), 1);
        check("fetch_retired", 32'(retired), 1);

        // Jump with simultaneous pc_en: 0xF4 = JMP 20
        fetch();
        check("jmp_opcode", 32'(opcode), 7);
        check("jmp_operand", 32'(operand), 20);
        pc_load = 1; jmp = 1; pc_en = 1;
        step();
        idle();
        check("jmp_pc", 32'(ins_addr), 20);
        check("jmp_retired", 32'(retired), 2);
        jmp = 1;
        step();
        jmp = 0;
        check("jmp_no_load_pc", 32'(ins_addr), 20);

        // Jump to 6 (0xE6), then skip and writeback increment
        fetch();
        pc_load = 1; jmp = 1;
        step();
        idle();
        check("to6_pc", 32'(ins_addr), 6);
        pc_load = 1; jmp = 0;
        step();
        idle();
        check("skip_pc", 32'(ins_addr), 7);
        step();
        pc_en = 1;
        step();
        pc_en = 0;
        check("skip_wb_pc", 32'(ins_addr), 8);
        check("skip_retired", 32'(retired), 3);

        // Tight loop: 0xE8 at address 8 = JMP 8
        fetch();
        pc_load = 1; jmp = 1;
        step();
        idle();
        check("loop_pc", 32'(ins_addr), 8);

        // Wrap of PC and retired counter
        rst = 0;
        step();
        rst = 1;
        pc_en = 1;
        repeat (65535) step();
        check("wrap_pre_retired", 32'(retired), 32'hFFFF);
        check("wrap_pre_pc", 32'(ins_addr), 31);
        step();
        pc_en = 0;
        check("wrap_retired", 32'(retired), 0);
        check("wrap_pc", 32'(ins_addr), 0);

        // Halt while a read is pending: 0x29 = opcode 1, operand 9
        mem[0] = 8'h29;
        memIns_en = 1;
        step();
        memIns_en = 0; halt = 1;
        step();
        halt = 0;
        check("halt_flag", 32'(halted), 1);
        check("halt_capture", {24'b0, opcode, operand}, 32'h29);
        mem[0] = 8'h77;
        memIns_en = 1; pc_en = 1; pc_load = 1; jmp = 1;
        #1;
        check("halt_ins_re", 32'(ins_re), 0);
        repeat (3) step();
        check("halt_pc", 32'(ins_addr), 0);
        check("halt_ir", {24'b0, opcode, operand}, 32'h29);
        check("halt_retired", 32'(retired), 0);
        check("halt_sticky", 32'(halted), 1);
        idle();
        rst = 0;
        step();
        rst = 1;
        check("halt_rst_clear", 32'(halted), 0);
        memIns_en = 1;
        #1;
        check("post_halt_ins_re", 32'(ins_re), 1);
        idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
